calendar_date_counter: RTL

Parametrised day-of-year calendar engine that keeps month, day-of-month and day-of-year registers for a configurable number of months, with leap-year handling, up/down stepping and a sequential load of an arbitrary day-of-year. It sits between the clock divider / day-tick source and the seven-segment encoders. It replaces combinational day-of-year-to-month decoding with registered, incrementally maintained state.

---
 rtl/calendar_date_counter_if.sv | 33 +++
 rtl/calendar_date_counter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/calendar_date_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calendar_date_counter_if                                                   |
// | Control and date-output bundle of the day-of-year calendar engine.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface calendar_date_counter_if #(
    parameter int DOY_W = 9
);
    logic             tick;
    logic             dir;
    logic             leap;
    logic             load;
    logic [DOY_W-1:0] load_doy;
    logic [DOY_W-1:0] doy;
    logic [3:0]       month;
    logic [4:0]       day;
    logic [7:0]       month_bcd;
    logic [7:0]       day_bcd;
    logic             busy;
    logic             wrap;

    modport master (
        output tick, dir, leap, load, load_doy,
        input  doy, month, day, month_bcd, day_bcd, busy, wrap
    );

    modport slave (
        input  tick, dir, leap, load, load_doy,
        output doy, month, day, month_bcd, day_bcd, busy, wrap
    );
endinterface
`default_nettype wire

// File: rtl/calendar_date_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | calendar_date_counter                                                      |
// | Registered month/day/day-of-year engine with leap years, up/down stepping  |
// | and a month-by-month load search. Define CALENDAR_BCD_EN for BCD outputs.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module calendar_date_counter #(
    parameter int MAX_MONTH = 12,
    parameter int DOY_W     = 9
) (
    input  logic                  clock,
    input  logic                  reset_n,
    calendar_date_counter_if.slave cal
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEEK = 1'b1
    } state_t;

    localparam logic [3:0] LAST_MONTH = 4'(MAX_MONTH);

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd2:                      month_len = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   month_len = 5'd30;
            default:                   month_len = 5'd31;
        endcase
    endfunction

    function automatic logic [DOY_W-1:0] year_len(input logic lp);
        int s;
        s = 0;
        for (int m = 1; m <= MAX_MONTH; m++) begin
            s += int'(month_len(4'(m), 1'b0));
        end
        if (lp && (MAX_MONTH >= 2)) begin
            s++;
        end
        return DOY_W'(s);
    endfunction

    state_t           r_state,    w_state_nx;
    logic [DOY_W-1:0] r_doy,      w_doy_nx;
    logic [3:0]       r_month,    w_month_nx;
    logic [4:0]       r_day,      w_day_nx;
    logic [DOY_W-1:0] r_rem,      w_rem_nx;
    logic [DOY_W-1:0] r_target,   w_target_nx;
    logic [3:0]       r_wm,       w_wm_nx;
    logic             r_leap_cap, w_leap_cap_nx;
    logic             r_wrap,     w_wrap_nx;

    logic [4:0]       w_cur_len;
    logic [4:0]       w_prev_len;
    logic [4:0]       w_wm_len;
    logic [DOY_W-1:0] w_year_len;
    logic [DOY_W-1:0] w_clamped;

    always_comb begin
        w_state_nx    = r_state;
        w_doy_nx      = r_doy;
        w_month_nx    = r_month;
        w_day_nx      = r_day;
        w_rem_nx      = r_rem;
        w_target_nx   = r_target;
        w_wm_nx       = r_wm;
        w_leap_cap_nx = r_leap_cap;
        w_wrap_nx     = 1'b0;

        w_cur_len  = month_len(r_month, cal.leap);
        w_prev_len = month_len(r_month - 4'd1, cal.leap);
        w_wm_len   = month_len(r_wm, r_leap_cap);
        w_year_len = year_len(cal.leap);

        if (cal.load_doy == '0) begin
            w_clamped = DOY_W'(1);
        end else if (cal.load_doy > w_year_len) begin
            w_clamped = w_year_len;
        end else begin
            w_clamped = cal.load_doy;
        end

        case (r_state)
            IDLE: begin
                if (cal.load) begin
                    w_rem_nx      = w_clamped;
                    w_target_nx   = w_clamped;
                    w_wm_nx       = 4'd1;
                    w_leap_cap_nx = cal.leap;
                    w_state_nx    = SEEK;
                end else if (cal.tick) begin
                    if (cal.dir) begin
                        // >= also rolls over a 29 February left behind when leap drops
                        if (r_day >= w_cur_len) begin
                            if (r_month == LAST_MONTH) begin
                                w_month_nx = 4'd1;
                                w_day_nx   = 5'd1;
                                w_doy_nx   = DOY_W'(1);
                                w_wrap_nx  = 1'b1;
                            end else begin
                                w_month_nx = r_month + 4'd1;
                                w_day_nx   = 5'd1;
                                w_doy_nx   = r_doy + DOY_W'(1);
                            end
                        end else begin
                            w_day_nx = r_day + 5'd1;
                            w_doy_nx = r_doy + DOY_W'(1);
                        end
                    end else begin
                        if (r_day == 5'd1) begin
                            if (r_month == 4'd1) begin
                                w_month_nx = LAST_MONTH;
                                w_day_nx   = month_len(LAST_MONTH, cal.leap);
                                w_doy_nx   = w_year_len;
                                w_wrap_nx  = 1'b1;
                            end else begin
                                w_month_nx = r_month - 4'd1;
                                w_day_nx   = w_prev_len;
                                w_doy_nx   = r_doy - DOY_W'(1);
                            end
                        end else begin
                            w_day_nx = r_day - 5'd1;
                            w_doy_nx = r_doy - DOY_W'(1);
                        end
                    end
                end
            end
            SEEK: begin
                if (r_rem > DOY_W'(w_wm_len)) begin
                    w_rem_nx = r_rem - DOY_W'(w_wm_len);
                    w_wm_nx  = r_wm + 4'd1;
                end else begin
                    w_month_nx = r_wm;
                    w_day_nx   = r_rem[4:0];
                    w_doy_nx   = r_target;
                    w_state_nx = IDLE;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_doy      <= DOY_W'(1);
            r_month    <= 4'd1;
            r_day      <= 5'd1;
            r_rem      <= '0;
            r_target   <= '0;
            r_wm       <= 4'd1;
            r_leap_cap <= 1'b0;
            r_wrap     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_doy      <= w_doy_nx;
            r_month    <= w_month_nx;
            r_day      <= w_day_nx;
            r_rem      <= w_rem_nx;
            r_target   <= w_target_nx;
            r_wm       <= w_wm_nx;
            r_leap_cap <= w_leap_cap_nx;
            r_wrap     <= w_wrap_nx;
        end
    end

    assign cal.doy   = r_doy;
    assign cal.month = r_month;
    assign cal.day   = r_day;
    assign cal.busy  = (r_state == SEEK);
    assign cal.wrap  = r_wrap;

`ifdef CALENDAR_BCD_EN
    function automatic logic [7:0] to_bcd(input logic [4:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 5'd10);
        ones = 4'(v - {1'b0, tens} * 5'd10);
        return {tens, ones};
    endfunction

    logic [7:0] r_month_bcd;
    logic [7:0] r_day_bcd;

    // Fed from the same next-state values so BCD and binary move together
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_month_bcd <= 8'h01;
            r_day_bcd   <= 8'h01;
        end else begin
            r_month_bcd <= to_bcd({1'b0, w_month_nx});
            r_day_bcd   <= to_bcd(w_day_nx);
        end
    end

    assign cal.month_bcd = r_month_bcd;
    assign cal.day_bcd   = r_day_bcd;
`else
    assign cal.month_bcd = 8'h00;
    assign cal.day_bcd   = 8'h00;
`endif
endmodule
`default_nettype wire
